// File: rtl/fetch_control_unit_pkg.sv
// Shared instruction-set encodings, field layout and sequencer state codes
// for the fetch/decode/execute control path.
package fetch_control_unit_pkg;

  localparam int unsigned ARG_WIDTH         = 5;
  localparam int unsigned REG_WIDTH         = 2;
  localparam int unsigned OPCODE_WIDTH      = 3;
  localparam int unsigned INSTRUCTION_WIDTH = OPCODE_WIDTH + REG_WIDTH + ARG_WIDTH;

  typedef logic [OPCODE_WIDTH-1:0]      opcode_t;
  typedef logic [REG_WIDTH-1:0]         reg_code_t;
  typedef logic [ARG_WIDTH-1:0]         arg_t;
  typedef logic [INSTRUCTION_WIDTH-1:0] instr_t;

  // Instruction word layout: {opcode, reg, arg}; opcode 3'd7 is undefined
  localparam opcode_t OP_NOP = 3'd0;
  localparam opcode_t OP_LD  = 3'd1;
  localparam opcode_t OP_ADD = 3'd2;
  localparam opcode_t OP_SUB = 3'd3;
  localparam opcode_t OP_XOR = 3'd4;
  localparam opcode_t OP_ST  = 3'd5;
  localparam opcode_t OP_JZ  = 3'd6;

  localparam reg_code_t R0 = 2'd0;
  localparam reg_code_t R1 = 2'd1;
  localparam reg_code_t R2 = 2'd2;
  localparam reg_code_t R3 = 2'd3;

  localparam logic [1:0] FSM_FETCH   = 2'd0;
  localparam logic [1:0] FSM_DECODE  = 2'd1;
  localparam logic [1:0] FSM_EXECUTE = 2'd2;

  localparam instr_t NOP_WORD = {OP_NOP, R0, arg_t'('0)};

  function automatic instr_t asm_reg(input opcode_t op, input reg_code_t r);
    return {op, r, arg_t'('0)};
  endfunction

  function automatic instr_t asm_arg(input opcode_t op, input arg_t a);
    return {op, R0, a};
  endfunction

  function automatic opcode_t ir_opcode(input instr_t ir);
    return ir[INSTRUCTION_WIDTH-1 -: OPCODE_WIDTH];
  endfunction

  function automatic reg_code_t ir_reg(input instr_t ir);
    return ir[ARG_WIDTH +: REG_WIDTH];
  endfunction

  function automatic arg_t ir_arg(input instr_t ir);
    return ir[ARG_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/fetch_control_unit_decoder.sv
// Combinational instruction decoder: splits the IR into fields and classifies
// the opcode into write-strobe / jump / illegal categories.
module instruction_decoder
  import fetch_control_unit_pkg::*;
(
  input  logic [INSTRUCTION_WIDTH-1:0] ir,
  output logic [OPCODE_WIDTH-1:0]      opcode,
  output logic [REG_WIDTH-1:0]         reg_field,
  output logic [ARG_WIDTH-1:0]         arg,
  output logic                         is_acc_write,
  output logic                         is_store,
  output logic                         is_jz,
  output logic                         is_illegal
);

  always_comb begin
    opcode       = ir_opcode(ir);
    reg_field    = ir_reg(ir);
    arg          = ir_arg(ir);
    is_acc_write = 1'b0;
    is_store     = 1'b0;
    is_jz        = 1'b0;
    is_illegal   = 1'b0;
    case (ir_opcode(ir))
      OP_NOP:                       ;
      OP_LD, OP_ADD, OP_SUB, OP_XOR: is_acc_write = 1'b1;
      OP_ST:                        is_store     = 1'b1;
      OP_JZ:                        is_jz        = 1'b1;
      default:                      is_illegal   = 1'b1;
    endcase
  end

endmodule

// File: rtl/fetch_control_unit.sv
// Three-phase instruction sequencer: fetches from the combinational ROM, decodes,
// and issues single-cycle execute strobes to the accumulator/register-file datapath.
module fetch_control_unit
  import fetch_control_unit_pkg::*;
#(
  parameter logic [ARG_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  output logic [ARG_WIDTH-1:0]         rom_address,
  input  logic [INSTRUCTION_WIDTH-1:0] rom_data,
  input  logic                         zero_flag,
  output logic [ARG_WIDTH-1:0]         pc,
  output logic [OPCODE_WIDTH-1:0]      alu_op,
  output logic [REG_WIDTH-1:0]         reg_sel,
  output logic                         acc_we,
  output logic                         reg_we,
  output logic                         exec_valid,
  output logic                         illegal
);

  logic [1:0]                   state_q, state_d;
  logic [ARG_WIDTH-1:0]         pc_q, pc_d;
  logic [INSTRUCTION_WIDTH-1:0] ir_q, ir_d;
  logic                         exec_valid_q, exec_valid_d;
  logic                         acc_we_q, acc_we_d;
  logic                         reg_we_q, reg_we_d;
  logic                         illegal_q, illegal_d;

  logic [OPCODE_WIDTH-1:0] dec_opcode;
  logic [REG_WIDTH-1:0]    dec_reg;
  logic [ARG_WIDTH-1:0]    dec_arg;
  logic                    dec_acc_write, dec_store, dec_jz, dec_illegal;

  instruction_decoder u_decoder (
    .ir           (ir_q),
    .opcode       (dec_opcode),
    .reg_field    (dec_reg),
    .arg          (dec_arg),
    .is_acc_write (dec_acc_write),
    .is_store     (dec_store),
    .is_jz        (dec_jz),
    .is_illegal   (dec_illegal)
  );

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ir_d         = ir_q;
    exec_valid_d = exec_valid_q;
    acc_we_d     = acc_we_q;
    reg_we_d     = reg_we_q;
    illegal_d    = illegal_q;
    if (enable) begin
      case (state_q)
        FSM_FETCH: begin
          ir_d    = rom_data;
          state_d = FSM_DECODE;
        end
        // Strobes are registered on entry to EXECUTE so they come straight off flops
        FSM_DECODE: begin
          state_d      = FSM_EXECUTE;
          exec_valid_d = 1'b1;
          acc_we_d     = dec_acc_write;
          reg_we_d     = dec_store;
          illegal_d    = illegal_q | dec_illegal;
        end
        FSM_EXECUTE: begin
          state_d      = FSM_FETCH;
          exec_valid_d = 1'b0;
          acc_we_d     = 1'b0;
          reg_we_d     = 1'b0;
          pc_d         = (dec_jz && zero_flag) ? dec_arg : pc_q + ARG_WIDTH'(1);
        end
        default: begin
          state_d      = FSM_FETCH;
          exec_valid_d = 1'b0;
          acc_we_d     = 1'b0;
          reg_we_d     = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= FSM_FETCH;
      pc_q         <= RESET_PC;
      ir_q         <= NOP_WORD;
      exec_valid_q <= 1'b0;
      acc_we_q     <= 1'b0;
      reg_we_q     <= 1'b0;
      illegal_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ir_q         <= ir_d;
      exec_valid_q <= exec_valid_d;
      acc_we_q     <= acc_we_d;
      reg_we_q     <= reg_we_d;
      illegal_q    <= illegal_d;
    end
  end

  // A stalled EXECUTE keeps its strobe flops set but must not present a strobe
  assign exec_valid  = exec_valid_q & enable;
  assign acc_we      = acc_we_q & enable;
  assign reg_we      = reg_we_q & enable;
  assign illegal     = illegal_q;
  assign pc          = pc_q;
  assign rom_address = pc_q;
  assign alu_op      = dec_opcode;
  assign reg_sel     = dec_reg;

endmodule

// File: tb/tb_fetch_control_unit.sv
// Bench for fetch_control_unit: ROM array, behavioural accumulator datapath and an
// instruction-level reference model stepped one clock at a time.
module tb_fetch_control_unit;
  import fetch_control_unit_pkg::*;

  logic                         clk = 1'b0;
  logic                         reset;
  logic                         enable;
  logic [ARG_WIDTH-1:0]         rom_address;
  logic [INSTRUCTION_WIDTH-1:0] rom_data;
  logic                         zero_flag;
  logic [ARG_WIDTH-1:0]         pc;
  logic [OPCODE_WIDTH-1:0]      alu_op;
  logic [REG_WIDTH-1:0]         reg_sel;
  logic                         acc_we, reg_we, exec_valid, illegal;

  always #5 clk = ~clk;

  fetch_control_unit #(.RESET_PC(5'd0)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .rom_address (rom_address),
    .rom_data    (rom_data),
    .zero_flag   (zero_flag),
    .pc          (pc),
    .alu_op      (alu_op),
    .reg_sel     (reg_sel),
    .acc_we      (acc_we),
    .reg_we      (reg_we),
    .exec_valid  (exec_valid),
    .illegal     (illegal)
  );

  instr_t mem [32];
  assign rom_data = mem[rom_address];

  // Behavioural datapath driven by the DUT strobes
  logic       dp_init;
  logic [7:0] init_acc;
  logic [7:0] init_regs [4];
  logic [7:0] dp_acc;
  logic [7:0] dp_regs [4];
  assign zero_flag = (dp_acc == 8'd0);

  always @(posedge clk) begin
    if (dp_init) begin
      dp_acc <= init_acc;
      for (int i = 0; i < 4; i++) dp_regs[i] <= init_regs[i];
    end else begin
      if (acc_we) begin
        case (alu_op)
          OP_LD:   dp_acc <= dp_regs[reg_sel];
          OP_ADD:  dp_acc <= dp_acc + dp_regs[reg_sel];
          OP_SUB:  dp_acc <= dp_acc - dp_regs[reg_sel];
          OP_XOR:  dp_acc <= dp_acc ^ dp_regs[reg_sel];
          default: ;
        endcase
      end
      if (reg_we) dp_regs[reg_sel] <= dp_acc;
    end
  end

  // Reference model: phase counts clocks within an instruction (0 fetch, 1 decode, 2 execute)
  logic [4:0] m_pc;
  int         m_phase;
  instr_t     m_ir;
  bit         m_illegal;
  logic [7:0] m_acc;
  logic [7:0] m_regs [4];

  int n_checks = 0;
  int n_pass   = 0;

  function automatic void model_reset();
    m_pc = 5'd0; m_phase = 0; m_ir = '0; m_illegal = 1'b0;
  endfunction

  function automatic void model_step();
    logic [2:0] op;
    logic [1:0] r;
    logic [4:0] a;
    op = m_ir[9:7]; r = m_ir[6:5]; a = m_ir[4:0];
    if (m_phase == 0) m_ir = mem[m_pc];
    else if (m_phase == 1) begin
      if (op == 3'd7) m_illegal = 1'b1;
    end else begin
      case (op)
        OP_LD:   m_acc = m_regs[r];
        OP_ADD:  m_acc = m_acc + m_regs[r];
        OP_SUB:  m_acc = m_acc - m_regs[r];
        OP_XOR:  m_acc = m_acc ^ m_regs[r];
        OP_ST:   m_regs[r] = m_acc;
        default: ;
      endcase
      if (op == OP_JZ && m_acc == 8'd0) m_pc = a;
      else m_pc = 5'((32'(m_pc) + 1) % 32);
    end
    m_phase = (m_phase + 1) % 3;
  endfunction

  function automatic bit e_exec();
    return enable && (m_phase == 2);
  endfunction
  function automatic bit e_acc();
    return e_exec() && (m_ir[9:7] inside {OP_LD, OP_ADD, OP_SUB, OP_XOR});
  endfunction
  function automatic bit e_st();
    return e_exec() && (m_ir[9:7] == OP_ST);
  endfunction

  task automatic tick();
    @(posedge clk);
    if (!reset && enable) model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; dp_init = 1'b1;
    model_reset();
    @(negedge clk); @(negedge clk);
    dp_init = 1'b0;
    n_checks++; if (pc !== 5'd0) $display("FAIL reset_pc got %0d exp 0", pc); else n_pass++;
    n_checks++; if (rom_address !== 5'd0) $display("FAIL reset_addr got %0d exp 0", rom_address); else n_pass++;
    n_checks++; if (exec_valid !== 1'b0) $display("FAIL reset_exec got %b exp 0", exec_valid); else n_pass++;
    n_checks++; if (acc_we !== 1'b0) $display("FAIL reset_acc_we got %b exp 0", acc_we); else n_pass++;
    n_checks++; if (reg_we !== 1'b0) $display("FAIL reset_reg_we got %b exp 0", reg_we); else n_pass++;
    n_checks++; if (illegal !== 1'b0) $display("FAIL reset_illegal got %b exp 0", illegal); else n_pass++;
    reset = 1'b0;
  endtask

  // LD R3 at 0, ST R2 at 1
  task automatic test_ld_st();
    for (int c = 1; c <= 6; c++) begin
      n_checks++; if (rom_address !== m_pc) $display("FAIL ldst_addr c%0d got %0d exp %0d", c, rom_address, m_pc); else n_pass++;
      n_checks++; if (exec_valid !== e_exec()) $display("FAIL ldst_exec c%0d got %b exp %b", c, exec_valid, e_exec()); else n_pass++;
      n_checks++; if (acc_we !== e_acc()) $display("FAIL ldst_acc_we c%0d got %b exp %b", c, acc_we, e_acc()); else n_pass++;
      n_checks++; if (reg_we !== e_st()) $display("FAIL ldst_reg_we c%0d got %b exp %b", c, reg_we, e_st()); else n_pass++;
      if (c == 3) begin
        n_checks++; if (acc_we !== 1'b1 || reg_sel !== R3) $display("FAIL ld_r3 got we=%b reg=%0d exp we=1 reg=3", acc_we, reg_sel); else n_pass++;
      end
      if (c == 6) begin
        n_checks++; if (reg_we !== 1'b1 || acc_we !== 1'b0 || reg_sel !== R2) $display("FAIL st_r2 got rwe=%b awe=%b reg=%0d exp 1 0 2", reg_we, acc_we, reg_sel); else n_pass++;
      end
      tick();
      if (c == 3) begin
        n_checks++; if (pc !== 5'd1) $display("FAIL ld_pc got %0d exp 1", pc); else n_pass++;
      end
    end
    n_checks++; if (pc !== 5'd2) $display("FAIL st_pc got %0d exp 2", pc); else n_pass++;
  endtask

  // XOR zeroes acc, taken JZ skips address 11, untaken JZ, NOP run wraps PC to 0
  task automatic test_jz_wrap();
    int seen11 = 0;
    int guard = 0;
    while (!(m_pc == 5'd12 && m_phase == 0) && guard < 100) begin
      if (rom_address == 5'd11) seen11++;
      tick(); guard++;
    end
    n_checks++; if (guard >= 100) $display("FAIL jz_reach_timeout got %0d cycles exp <100", guard); else n_pass++;
    n_checks++; if (pc !== 5'd12) $display("FAIL jz_taken_pc got %0d exp 12", pc); else n_pass++;
    n_checks++; if (zero_flag !== 1'b1) $display("FAIL jz_zero_flag got %b exp 1", zero_flag); else n_pass++;
    n_checks++; if (seen11 !== 0) $display("FAIL jz_skip11 got %0d fetches exp 0", seen11); else n_pass++;
    repeat (6) tick();
    n_checks++; if (pc !== 5'd14) $display("FAIL jz_not_taken_pc got %0d exp 14", pc); else n_pass++;
    n_checks++; if (dp_acc !== m_acc) $display("FAIL jz_acc got %0h exp %0h", dp_acc, m_acc); else n_pass++;
    for (int k = 0; k < 18 * 3; k++) begin
      if (rom_address !== pc) begin
        n_checks++; $display("FAIL addr_eq_pc got %0d exp %0d", rom_address, pc);
      end
      tick();
    end
    n_checks++; if (pc !== 5'd0) $display("FAIL wrap_pc got %0d exp 0", pc); else n_pass++;
  endtask

  // Stall for 5 cycles in DECODE of LD R3, then stall once inside EXECUTE
  task automatic test_stall();
    tick();
    enable = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_checks++; if (pc !== 5'd0 || rom_address !== 5'd0) $display("FAIL stall_pc c%0d got %0d exp 0", c, pc); else n_pass++;
      n_checks++; if ({exec_valid, acc_we, reg_we} !== 3'b000) $display("FAIL stall_strobes c%0d got %b exp 000", c, {exec_valid, acc_we, reg_we}); else n_pass++;
      tick();
    end
    enable = 1'b1; #1;
    n_checks++; if (exec_valid !== 1'b0) $display("FAIL resume_still_decode got %b exp 0", exec_valid); else n_pass++;
    tick();
    n_checks++; if (exec_valid !== 1'b1 || acc_we !== 1'b1 || reg_sel !== R3) $display("FAIL resume_exec got %b%b reg=%0d exp 11 reg=3", exec_valid, acc_we, reg_sel); else n_pass++;
    enable = 1'b0; #1;
    n_checks++; if ({exec_valid, acc_we} !== 2'b00) $display("FAIL stall_exec_strobes got %b exp 00", {exec_valid, acc_we}); else n_pass++;
    tick();
    enable = 1'b1; #1;
    n_checks++; if (acc_we !== 1'b1 || pc !== 5'd0) $display("FAIL exec_after_stall got we=%b pc=%0d exp we=1 pc=0", acc_we, pc); else n_pass++;
    tick();
    n_checks++; if (pc !== 5'd1) $display("FAIL stall_done_pc got %0d exp 1", pc); else n_pass++;
    n_checks++; if (dp_acc !== m_acc) $display("FAIL stall_acc got %0h exp %0h", dp_acc, m_acc); else n_pass++;
  endtask

  // Reset aborts an ADD in EXECUTE; an undefined opcode later sets sticky illegal
  task automatic test_reset_exec();
    logic [7:0] acc_before;
    mem[0] = asm_reg(OP_ADD, R1);
    mem[1] = 10'h3E0;
    mem[2] = asm_reg(OP_NOP, R0);
    reset = 1'b1; model_reset();
    @(negedge clk); reset = 1'b0;
    tick(); tick();
    n_checks++; if (acc_we !== 1'b1) $display("FAIL add_exec_we got %b exp 1", acc_we); else n_pass++;
    acc_before = dp_acc;
    #2 reset = 1'b1;
    #1;
    n_checks++; if ({exec_valid, acc_we} !== 2'b00) $display("FAIL reset_abort_strobes got %b exp 00", {exec_valid, acc_we}); else n_pass++;
    n_checks++; if (pc !== 5'd0) $display("FAIL reset_abort_pc got %0d exp 0", pc); else n_pass++;
    model_reset();
    @(negedge clk); reset = 1'b0;
    n_checks++; if (dp_acc !== acc_before) $display("FAIL reset_no_commit got %0h exp %0h", dp_acc, acc_before); else n_pass++;
    repeat (3) tick();
    n_checks++; if (pc !== 5'd1 || dp_acc !== m_acc) $display("FAIL add_rerun got pc=%0d acc=%0h exp pc=1 acc=%0h", pc, dp_acc, m_acc); else n_pass++;
    tick(); tick();
    n_checks++; if (illegal !== 1'b1 || exec_valid !== 1'b1) $display("FAIL illegal_flag got ill=%b ev=%b exp 1 1", illegal, exec_valid); else n_pass++;
    n_checks++; if ({acc_we, reg_we} !== 2'b00) $display("FAIL illegal_no_write got %b exp 00", {acc_we, reg_we}); else n_pass++;
    tick();
    n_checks++; if (pc !== 5'd2) $display("FAIL illegal_pc got %0d exp 2", pc); else n_pass++;
    repeat (4) tick();
    n_checks++; if (illegal !== 1'b1) $display("FAIL illegal_sticky got %b exp 1", illegal); else n_pass++;
  endtask

  // Random program and random enable compared against the model every cycle
  task automatic test_random();
    for (int i = 0; i < 32; i++) mem[i] = instr_t'($urandom);
    reset = 1'b1; model_reset();
    @(negedge clk); reset = 1'b0;
    for (int c = 0; c < 400; c++) begin
      enable = ($urandom_range(0, 9) < 8);
      #1;
      n_checks++; if (pc !== m_pc || rom_address !== m_pc) $display("FAIL rnd_pc c%0d got %0d/%0d exp %0d", c, pc, rom_address, m_pc); else n_pass++;
      n_checks++; if (exec_valid !== e_exec()) $display("FAIL rnd_exec c%0d got %b exp %b", c, exec_valid, e_exec()); else n_pass++;
      n_checks++; if (acc_we !== e_acc()) $display("FAIL rnd_acc_we c%0d got %b exp %b", c, acc_we, e_acc()); else n_pass++;
      n_checks++; if (reg_we !== e_st()) $display("FAIL rnd_reg_we c%0d got %b exp %b", c, reg_we, e_st()); else n_pass++;
      n_checks++; if (illegal !== m_illegal) $display("FAIL rnd_illegal c%0d got %b exp %b", c, illegal, m_illegal); else n_pass++;
      n_checks++; if (acc_we && reg_we) $display("FAIL rnd_excl c%0d got 11 exp not both", c); else n_pass++;
      if (e_exec()) begin
        n_checks++; if (alu_op !== m_ir[9:7] || reg_sel !== m_ir[6:5]) $display("FAIL rnd_fields c%0d got %0d/%0d exp %0d/%0d", c, alu_op, reg_sel, m_ir[9:7], m_ir[6:5]); else n_pass++;
      end
      tick();
    end
    enable = 1'b1;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; dp_init = 1'b1;
    init_acc = 8'($urandom);
    for (int i = 0; i < 4; i++) init_regs[i] = 8'($urandom);
    init_regs[3] = 8'($urandom_range(1, 255));
    m_acc = init_acc;
    for (int i = 0; i < 4; i++) m_regs[i] = init_regs[i];
    mem[0] = asm_reg(OP_LD, R3);
    mem[1] = asm_reg(OP_ST, R2);
    for (int i = 2; i < 8; i++) begin
      int k;
      k = $urandom_range(0, 5);
      case (k)
        0: mem[i] = asm_reg(OP_NOP, reg_code_t'($urandom));
        1: mem[i] = asm_reg(OP_LD,  reg_code_t'($urandom));
        2: mem[i] = asm_reg(OP_ADD, reg_code_t'($urandom));
        3: mem[i] = asm_reg(OP_SUB, reg_code_t'($urandom));
        4: mem[i] = asm_reg(OP_XOR, reg_code_t'($urandom));
        default: mem[i] = asm_reg(OP_ST, R0);
      endcase
    end
    mem[8]  = asm_reg(OP_LD, R1);
    mem[9]  = asm_reg(OP_XOR, R1);
    mem[10] = asm_arg(OP_JZ, 5'd12);
    mem[11] = asm_reg(OP_ST, R0);
    mem[12] = asm_reg(OP_ADD, R3);
    mem[13] = asm_arg(OP_JZ, 5'd5);
    for (int i = 14; i < 32; i++) mem[i] = NOP_WORD;

    test_reset();
    test_ld_st();
    test_jz_wrap();
    test_stall();
    test_reset_exec();
    test_random();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule
